freelist_ckpt: RTL and testbench

FREELIST_CKPT -- requirements
Module: freelist_ckpt

---
 rtl/freelist_ckpt.sv | 135 +++++++++++++
 tb/tb_freelist_ckpt.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/freelist_ckpt.sv
// Physical-register free list with branch checkpoints: a circular buffer of free
// tags, WAYS-wide allocate and free-back per cycle, head snapshot/restore on mispredict.
module freelist_ckpt #(
  parameter int NUM_PR   = 64,
  parameter int NUM_AR   = 32,
  parameter int WAYS     = 3,
  parameter int NUM_CKPT = 4,
  localparam int PRW     = $clog2(NUM_PR),
  localparam int DEPTH   = NUM_PR - NUM_AR,
  localparam int CKW     = $clog2(NUM_CKPT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WAYS-1:0]           DispatchEN,
  input  logic [WAYS-1:0]           RetireEN,
  input  logic [WAYS-1:0][PRW-1:0]  RetireReg,
  input  logic                      CkptEN,
  input  logic [CKW-1:0]            CkptID,
  input  logic                      BPRecoverEN,
  input  logic [CKW-1:0]            RecoverID,
  output logic [WAYS-1:0][PRW-1:0]  FreeReg,
  output logic [WAYS-1:0]           FreeRegValid,
  output logic [PRW:0]              FreeCount,
  output logic                      OverflowErr
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(WAYS + 1);
  localparam int LW = IW + 3;

  typedef struct packed {
    logic          wrap;
    logic [IW-1:0] idx;
  } ptr_t;

  function automatic ptr_t ptr_add(input ptr_t p, input logic [NW-1:0] k);
    logic [IW:0] sum;
    ptr_t        r;
    sum = {1'b0, p.idx} + (IW+1)'(k);
    if (sum >= (IW+1)'(DEPTH)) begin
      r.idx  = IW'(sum - (IW+1)'(DEPTH));
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = sum[IW-1:0];
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  // Linear position in [0, 2*DEPTH); the distance is taken modulo 2*DEPTH.
  function automatic logic [LW-1:0] ptr_lin(input ptr_t p);
    return p.wrap ? (LW'(DEPTH) + LW'(p.idx)) : LW'(p.idx);
  endfunction

  function automatic logic [LW-1:0] ptr_dist(input ptr_t t, input ptr_t h);
    logic [LW-1:0] d;
    d = ptr_lin(t) + LW'(2 * DEPTH) - ptr_lin(h);
    if (d >= LW'(2 * DEPTH)) d = d - LW'(2 * DEPTH);
    return d;
  endfunction

  function automatic logic [NW-1:0] popcnt(input logic [WAYS-1:0] v);
    logic [NW-1:0] c;
    c = '0;
    for (int i = 0; i < WAYS; i++) c = c + NW'(v[i]);
    return c;
  endfunction

  logic [PRW-1:0] buf_q [DEPTH];
  ptr_t           ckpt_q [NUM_CKPT];
  ptr_t           head_q, head_d, tail_q, tail_d, head_disp;
  logic           ovf_q, ovf_d;
  logic [LW-1:0]  cnt_w, room_w;
  logic [NW-1:0]  n_alloc, n_ret;
  logic           room_ok;
  logic [WAYS-1:0] wr_en;
  logic [IW-1:0]  wr_idx [WAYS];

  always_comb begin
    ptr_t rp;
    rp           = head_q;
    cnt_w        = ptr_dist(tail_q, head_q);
    FreeReg      = '0;
    FreeRegValid = '0;
    for (int i = 0; i < WAYS; i++) begin
      rp              = ptr_add(head_q, NW'(i));
      FreeReg[i]      = buf_q[rp.idx];
      FreeRegValid[i] = (cnt_w > LW'(i));
    end
    FreeCount   = (PRW+1)'(cnt_w);
    OverflowErr = ovf_q;
  end

  // Room is judged against the head after this cycle's dispatch or recovery,
  // so slots being handed out this cycle can be refilled in the same edge.
  always_comb begin
    ptr_t          wp;
    logic [NW-1:0] off;
    n_alloc   = popcnt(DispatchEN & FreeRegValid);
    head_disp = ptr_add(head_q, n_alloc);
    head_d    = BPRecoverEN ? ckpt_q[RecoverID] : head_disp;
    n_ret     = popcnt(RetireEN);
    room_w    = ptr_dist(tail_q, head_d) + LW'(n_ret);
    room_ok   = (room_w <= LW'(DEPTH));
    tail_d    = room_ok ? ptr_add(tail_q, n_ret) : tail_q;
    ovf_d     = ovf_q | ((|RetireEN) & ~room_ok);
    off       = '0;
    wp        = tail_q;
    for (int j = 0; j < WAYS; j++) begin
      wp        = ptr_add(tail_q, off);
      wr_idx[j] = wp.idx;
      wr_en[j]  = RetireEN[j] & room_ok;
      off       = off + NW'(RetireEN[j]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) buf_q[k] <= PRW'(NUM_AR + k);
      for (int c = 0; c < NUM_CKPT; c++) ckpt_q[c] <= '0;
      head_q <= '0;
      tail_q <= {1'b1, IW'(0)};
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      for (int j = 0; j < WAYS; j++) begin
        if (wr_en[j]) buf_q[wr_idx[j]] <= RetireReg[j];
      end
      if (CkptEN && !BPRecoverEN) ckpt_q[CkptID] <= head_disp;
    end
  end

endmodule

// File: tb/tb_freelist_ckpt.sv
// Scoreboard bench for freelist_ckpt: the driver pushes model-predicted outputs,
// a negedge monitor pops and compares them; directed checks plus random traffic.
module tb_freelist_ckpt;
  localparam int NUM_PR = 64, NUM_AR = 32, WAYS = 3, NUM_CKPT = 4;
  localparam int PRW = 6, DEPTH = 32, CKW = 2;

  logic                     clock, reset;
  logic [WAYS-1:0]          DispatchEN, RetireEN;
  logic [WAYS-1:0][PRW-1:0] RetireReg;
  logic                     CkptEN, BPRecoverEN;
  logic [CKW-1:0]           CkptID, RecoverID;
  logic [WAYS-1:0][PRW-1:0] FreeReg;
  logic [WAYS-1:0]          FreeRegValid;
  logic [PRW:0]             FreeCount;
  logic                     OverflowErr;

  freelist_ckpt #(.NUM_PR(NUM_PR), .NUM_AR(NUM_AR), .WAYS(WAYS), .NUM_CKPT(NUM_CKPT)) dut (
    .clock(clock), .reset(reset), .DispatchEN(DispatchEN), .RetireEN(RetireEN),
    .RetireReg(RetireReg), .CkptEN(CkptEN), .CkptID(CkptID), .BPRecoverEN(BPRecoverEN),
    .RecoverID(RecoverID), .FreeReg(FreeReg), .FreeRegValid(FreeRegValid),
    .FreeCount(FreeCount), .OverflowErr(OverflowErr));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [WAYS-1:0][PRW-1:0] fr;
    logic [WAYS-1:0]          v;
    logic [PRW:0]             cnt;
    logic                     err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: free tags in an array, head/tail as plain positions mod 2*DEPTH.
  int mbuf[DEPTH];
  int mh, mt;
  int mck[NUM_CKPT];
  bit merr;

  function automatic int mcount();
    return (mt - mh + 2 * DEPTH) % (2 * DEPTH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) mbuf[k] = NUM_AR + k;
    for (int c = 0; c < NUM_CKPT; c++) mck[c] = 0;
    mh   = 0;
    mt   = DEPTH;
    merr = 1'b0;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    int   cnt;
    cnt = mcount();
    e   = '0;
    for (int i = 0; i < WAYS; i++) begin
      e.fr[i] = PRW'(mbuf[(mh + i) % DEPTH]);
      e.v[i]  = (cnt > i);
    end
    e.cnt = (PRW+1)'(cnt);
    e.err = merr;
    return e;
  endfunction

  task automatic model_step(input logic [WAYS-1:0] d, input logic [WAYS-1:0] r,
                            input logic [WAYS-1:0][PRW-1:0] rr, input logic ce, input int cid,
                            input logic re, input int rid, input logic rs);
    int cnt, n, hd, nh, m, mid, off;
    if (rs) begin
      model_reset();
      return;
    end
    cnt = mcount();
    n = 0;
    for (int i = 0; i < WAYS; i++) if (d[i] && cnt > i) n++;
    hd = (mh + n) % (2 * DEPTH);
    nh = re ? mck[rid] : hd;
    if (ce && !re) mck[cid] = hd;
    m = $countones(r);
    if (m > 0) begin
      mid = (mt - nh + 2 * DEPTH) % (2 * DEPTH);
      if (mid + m > DEPTH) merr = 1'b1;
      else begin
        off = 0;
        for (int j = 0; j < WAYS; j++) begin
          if (r[j]) begin
            mbuf[(mt + off) % DEPTH] = int'(rr[j]);
            off++;
          end
        end
        mt = (mt + m) % (2 * DEPTH);
      end
    end
    mh = nh;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: predict outputs for the current state, drive, advance the model.
  task automatic step(input logic [WAYS-1:0] d, input logic [WAYS-1:0] r,
                      input logic [WAYS-1:0][PRW-1:0] rr, input logic ce, input int cid,
                      input logic re, input int rid, input logic rs);
    exp_q.push_back(model_exp());
    DispatchEN  = d;
    RetireEN    = r;
    RetireReg   = rr;
    CkptEN      = ce;
    CkptID      = CKW'(cid);
    BPRecoverEN = re;
    RecoverID   = CKW'(rid);
    reset       = rs;
    model_step(d, r, rr, ce, cid, re, rid, rs);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step('0, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < WAYS; i++)
          chk($sformatf("FreeReg[%0d]", i), int'(FreeReg[i]), int'(e.fr[i]));
        chk("FreeRegValid", int'(FreeRegValid), int'(e.v));
        chk("FreeCount", int'(FreeCount), int'(e.cnt));
        chk("OverflowErr", int'(OverflowErr), int'(e.err));
      end
    end
  end

  initial begin
    logic [WAYS-1:0]          rd, rr_en;
    logic [WAYS-1:0][PRW-1:0] rtags;
    int                       k;
    reset = 1'b1; DispatchEN = '0; RetireEN = '0; RetireReg = '0;
    CkptEN = 1'b0; CkptID = '0; BPRecoverEN = 1'b0; RecoverID = '0;
    @(posedge clock);
    #1;
    model_reset();

    chk("rst_fr0", int'(FreeReg[0]), 32);
    chk("rst_fr1", int'(FreeReg[1]), 33);
    chk("rst_fr2", int'(FreeReg[2]), 34);
    chk("rst_valid", int'(FreeRegValid), 7);
    chk("rst_cnt", int'(FreeCount), 32);

    step(3'b011, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("disp_fr0", int'(FreeReg[0]), 34);
    chk("disp_cnt", int'(FreeCount), 30);

    // reset must win over simultaneous requests
    step(3'b111, 3'b111, {6'd1, 6'd2, 6'd3}, 1'b1, 1, 1'b1, 0, 1'b1);
    chk("midrst_cnt", int'(FreeCount), 32);
    chk("midrst_fr0", int'(FreeReg[0]), 32);

    step(3'b001, '0, '0, 1'b1, 2, 1'b0, 0, 1'b0);
    repeat (3) step(3'b111, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("pre_rec_cnt", int'(FreeCount), 22);
    step(3'b111, '0, '0, 1'b1, 3, 1'b1, 2, 1'b0);
    chk("rec_fr0", int'(FreeReg[0]), 33);
    chk("rec_cnt", int'(FreeCount), 31);

    // fresh checkpoint at head 3, advance, then recover together with two retires
    step(3'b011, '0, '0, 1'b1, 1, 1'b0, 0, 1'b0);
    repeat (2) step(3'b111, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    step(3'b000, 3'b101, {6'd9, 6'd44, 6'd7}, 1'b0, 0, 1'b1, 1, 1'b0);
    chk("retrec_cnt", int'(FreeCount), 31);
    repeat (9) step(3'b111, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("wrap_fr0", int'(FreeReg[0]), 62);
    chk("wrap_fr2", int'(FreeReg[2]), 7);
    step(3'b011, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("tail_fr0", int'(FreeReg[0]), 7);
    chk("tail_fr1", int'(FreeReg[1]), 9);
    chk("tail_cnt", int'(FreeCount), 2);

    step(3'b011, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("drain_valid", int'(FreeRegValid), 0);
    chk("drain_cnt", int'(FreeCount), 0);
    step(3'b111, '0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("empty_disp_cnt", int'(FreeCount), 0);
    step(3'b111, 3'b010, {6'd0, 6'd5, 6'd0}, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("refill_fr0", int'(FreeReg[0]), 5);
    chk("refill_cnt", int'(FreeCount), 1);

    step('0, '0, '0, 1'b0, 0, 1'b0, 0, 1'b1);
    step('0, 3'b001, {6'd0, 6'd0, 6'd10}, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("ovf_err", int'(OverflowErr), 1);
    chk("ovf_cnt", int'(FreeCount), 32);
    idle();
    chk("ovf_hold", int'(OverflowErr), 1);
    step(3'b111, 3'b111, {6'd1, 6'd2, 6'd3}, 1'b1, 2, 1'b1, 1, 1'b1);
    chk("ovf_clr", int'(OverflowErr), 0);
    chk("ovf_clr_cnt", int'(FreeCount), 32);

    for (int c = 0; c < 3000; c++) begin
      k  = $urandom_range(0, WAYS);
      rd = WAYS'((1 << k) - 1);
      rr_en = ($urandom_range(0, 1) == 0) ? '0 : WAYS'($urandom);
      for (int j = 0; j < WAYS; j++) rtags[j] = PRW'($urandom);
      step(rd, rr_en, rtags, ($urandom_range(0, 3) == 0), $urandom_range(0, NUM_CKPT - 1),
           ($urandom_range(0, 19) == 0), $urandom_range(0, NUM_CKPT - 1),
           ($urandom_range(0, 199) == 0));
    end
    idle();

    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
